// File: rtl/drop_pkg.sv
// rtl/drop_pkg.sv - shared encodings, display patterns and defaults for drop_sequencer
// Contents: state encoding, msg_sel codes, seven-segment patterns, default parameters.
// Segment patterns are active-high, bit order g..a (bit 6 = g, bit 0 = a); four digits,
// leftmost digit in the most significant 7 bits.
package drop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_DROP = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MSG_BLANK = 2'd0,
    MSG_HOT   = 2'd1,
    MSG_DROP  = 2'd2,
    MSG_COLD  = 2'd3
  } msg_e;

  localparam int DEF_CONFIRM     = 3;
  localparam int DEF_DROP_CYCLES = 8;
  localparam int DEF_COOL_CYCLES = 16;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_H    = 7'h76;
  localparam logic [6:0] SEG_O_LO = 7'h5C;
  localparam logic [6:0] SEG_T_LO = 7'h78;
  localparam logic [6:0] SEG_D_LO = 7'h5E;
  localparam logic [6:0] SEG_R_LO = 7'h50;
  localparam logic [6:0] SEG_O_UP = 7'h3F;
  localparam logic [6:0] SEG_P    = 7'h73;
  localparam logic [6:0] SEG_C    = 7'h39;
  localparam logic [6:0] SEG_L    = 7'h38;

  localparam logic [27:0] DISP_BLANK = {SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF};
  localparam logic [27:0] DISP_HOT   = {SEG_OFF, SEG_H, SEG_O_LO, SEG_T_LO};
  localparam logic [27:0] DISP_DROP  = {SEG_D_LO, SEG_R_LO, SEG_O_UP, SEG_P};
  localparam logic [27:0] DISP_COLD  = {SEG_C, SEG_O_LO, SEG_L, SEG_D_LO};

  function automatic logic [27:0] msg_to_disp(input msg_e m);
    case (m)
      MSG_HOT:  return DISP_HOT;
      MSG_DROP: return DISP_DROP;
      MSG_COLD: return DISP_COLD;
      default:  return DISP_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/drop_sequencer_if.sv
// rtl/drop_sequencer_if.sv - sample/control/status bundle of drop_sequencer
// Inputs to the sequencer: sample_valid, t_act[15:0], t_lim[15:0], drop_en, abort.
// Outputs from the sequencer: drop_activated, busy, state_code[1:0], msg_sel[1:0], drop_count[7:0].
interface drop_sequencer_if;
  logic        sample_valid;
  logic [15:0] t_act;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        abort;
  logic        drop_activated;
  logic        busy;
  logic [1:0]  state_code;
  logic [1:0]  msg_sel;
  logic [7:0]  drop_count;

  modport master (
    output sample_valid, t_act, t_lim, drop_en, abort,
    input  drop_activated, busy, state_code, msg_sel, drop_count
  );

  modport slave (
    input  sample_valid, t_act, t_lim, drop_en, abort,
    output drop_activated, busy, state_code, msg_sel, drop_count
  );
endinterface

// File: rtl/drop_timer.sv
// rtl/drop_timer.sv - 16-bit loadable down-counter shared by the DROP and COOL phases
// Ports: clk, rst (sync active-high), i_load (load i_value this edge), i_value[15:0],
//        o_expire (count == 1, i.e. the current phase ends on the next edge).
module drop_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_value,
  output logic        o_expire
);

  logic [15:0] r_count;

  // Stops at zero so an idle timer never wraps into a spurious expire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != 16'd0) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign o_expire = (r_count == 16'd1);

endmodule

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - drop actuator sequencer: qualify, fire, hold, cool down
// Ports: clk, rst (sync active-high), bus (drop_sequencer_if.slave: samples, enable,
//        abort in; drop_activated, busy, state_code, msg_sel, drop_count out).
// Parameters: CONFIRM (1..15), DROP_CYCLES (1..65535), COOL_CYCLES (1..65535).
module drop_sequencer
  import drop_pkg::*;
#(
  parameter int CONFIRM     = DEF_CONFIRM,
  parameter int DROP_CYCLES = DEF_DROP_CYCLES,
  parameter int COOL_CYCLES = DEF_COOL_CYCLES
) (
  input logic               clk,
  input logic               rst,
  drop_sequencer_if.slave   bus
);

  state_e      r_state;
  state_e      w_next;
  logic [3:0]  r_conf_cnt;
  logic [3:0]  w_conf_next;
  msg_e        r_msg;
  msg_e        w_msg_next;
  logic        r_drop_act;
  logic        r_busy;
  logic [7:0]  r_drop_count;
  logic        w_qual;
  logic        w_load;
  logic [15:0] w_load_val;
  logic        w_expire;
  logic        w_enter_drop;

  drop_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  always_comb begin
    w_qual      = bus.sample_valid && bus.drop_en && (bus.t_act < bus.t_lim);
    w_next      = r_state;
    w_conf_next = r_conf_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_qual) begin
          w_conf_next = 4'd1;
          w_next      = (CONFIRM == 1) ? ST_DROP : ST_ARM;
        end
      end
      ST_ARM: begin
        // Losing the enable disarms even on cycles without a sample.
        if (!bus.drop_en) begin
          w_next      = ST_IDLE;
          w_conf_next = 4'd0;
        end else if (bus.sample_valid) begin
          if (w_qual) begin
            w_conf_next = r_conf_cnt + 4'd1;
            if (w_conf_next == 4'(CONFIRM)) begin
              w_next = ST_DROP;
            end
          end else begin
            w_next      = ST_IDLE;
            w_conf_next = 4'd0;
          end
        end
      end
      ST_DROP: begin
        if (bus.abort || !bus.drop_en || w_expire) begin
          w_next = ST_COOL;
        end
      end
      ST_COOL: begin
        if (w_expire) begin
          w_next      = ST_IDLE;
          w_conf_next = 4'd0;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The timer is loaded on the same edge that enters DROP or COOL.
  always_comb begin
    w_enter_drop = (w_next == ST_DROP) && (r_state != ST_DROP);
    w_load       = 1'b0;
    w_load_val   = 16'(DROP_CYCLES);
    if (w_enter_drop) begin
      w_load = 1'b1;
    end else if ((w_next == ST_COOL) && (r_state != ST_COOL)) begin
      w_load     = 1'b1;
      w_load_val = 16'(COOL_CYCLES);
    end
  end

  // Equal temperatures, or a disabled unit that is not cold, leave the message alone.
  always_comb begin
    w_msg_next = r_msg;
    if (w_next == ST_DROP) begin
      w_msg_next = MSG_DROP;
    end else if (bus.sample_valid) begin
      if (bus.drop_en && (bus.t_act > bus.t_lim)) begin
        w_msg_next = MSG_HOT;
      end else if (bus.t_act < bus.t_lim) begin
        w_msg_next = bus.drop_en ? MSG_BLANK : MSG_COLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_conf_cnt   <= 4'd0;
      r_msg        <= MSG_BLANK;
      r_drop_act   <= 1'b0;
      r_busy       <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_conf_cnt <= w_conf_next;
      r_msg      <= w_msg_next;
      r_drop_act <= (w_next == ST_DROP);
      r_busy     <= (w_next != ST_IDLE);
      if (w_enter_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign bus.drop_activated = r_drop_act;
  assign bus.busy           = r_busy;
  assign bus.state_code     = r_state;
  assign bus.msg_sel        = r_msg;
  assign bus.drop_count     = r_drop_count;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb/tb_drop_sequencer.sv - scoreboard bench for drop_sequencer (two parameter sets)
module tb_drop_sequencer;
  import drop_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drop_sequencer_if if_a ();
  drop_sequencer_if if_b ();

  drop_sequencer #(.CONFIRM(3), .DROP_CYCLES(8), .COOL_CYCLES(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  drop_sequencer #(.CONFIRM(1), .DROP_CYCLES(1), .COOL_CYCLES(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  typedef struct packed {
    logic       da;
    logic       busy;
    logic [1:0] sc;
    logic [1:0] msg;
    logic [7:0] cnt;
  } obs_t;

  // Remaining-clock view of the sequencer: the phase is implied by which count is live.
  typedef struct {
    int streak;
    int drop_left;
    int cool_left;
    int count;
    int msg;
  } model_t;

  typedef struct {
    bit v;
    int act;
    int lim;
    bit en;
    bit ab;
    bit r;
  } stim_t;

  model_t ma, mb;
  obs_t   qa[$];
  obs_t   qb[$];
  int     errors = 0;
  int     checks = 0;

  function automatic model_t step(model_t m, stim_t s, int conf, int dc, int cc);
    model_t n;
    n = m;
    if (s.r) begin
      n.streak = 0; n.drop_left = 0; n.cool_left = 0; n.count = 0; n.msg = 0;
      return n;
    end
    if (m.drop_left > 0) begin
      if (s.ab || !s.en || m.drop_left == 1) begin
        n.drop_left = 0;
        n.cool_left = cc;
      end else begin
        n.drop_left = m.drop_left - 1;
      end
    end else if (m.cool_left > 0) begin
      n.cool_left = m.cool_left - 1;
    end else if (!s.en) begin
      n.streak = 0;
    end else if (s.v) begin
      if (s.act < s.lim) begin
        n.streak = m.streak + 1;
        if (n.streak >= conf) begin
          n.streak    = 0;
          n.drop_left = dc;
          n.count     = (m.count < 255) ? m.count + 1 : 255;
        end
      end else begin
        n.streak = 0;
      end
    end
    if (n.drop_left > 0) n.msg = 2;
    else if (s.v) begin
      if (s.en && s.act > s.lim) n.msg = 1;
      else if (s.act < s.lim) n.msg = s.en ? 0 : 3;
    end
    return n;
  endfunction

  function automatic obs_t observe(model_t m);
    obs_t o;
    o.da   = (m.drop_left > 0);
    o.sc   = (m.drop_left > 0) ? 2'd2 : (m.cool_left > 0) ? 2'd3 : (m.streak > 0) ? 2'd1 : 2'd0;
    o.busy = (o.sc != 2'd0);
    o.msg  = m.msg[1:0];
    o.cnt  = m.count[7:0];
    return o;
  endfunction

  task automatic cycle(input bit v, input int act, input int lim, input bit en, input bit ab, input bit r);
    stim_t s;
    obs_t  ea, eb;
    s = '{v, act, lim, en, ab, r};
    rst = r;
    if_a.sample_valid = v; if_a.t_act = 16'(act); if_a.t_lim = 16'(lim);
    if_a.drop_en = en; if_a.abort = ab;
    if_b.sample_valid = v; if_b.t_act = 16'(act); if_b.t_lim = 16'(lim);
    if_b.drop_en = en; if_b.abort = ab;
    ma = step(ma, s, 3, 8, 16);
    mb = step(mb, s, 1, 1, 2);
    ea = observe(ma);
    eb = observe(mb);
    @(posedge clk);
    qa.push_back(ea);
    qb.push_back(eb);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic samp(input int act, input int lim, input bit en);
    cycle(1'b1, act, lim, en, 1'b0, 1'b0);
  endtask

  obs_t xa, ga, xb, gb;
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      xa = qa.pop_front();
      ga = {if_a.drop_activated, if_a.busy, if_a.state_code, if_a.msg_sel, if_a.drop_count};
      checks++;
      if (ga !== xa) begin
        errors++;
        $display("FAIL dut_a t=%0t got da=%b busy=%b sc=%0d msg=%0d cnt=%0d want da=%b busy=%b sc=%0d msg=%0d cnt=%0d",
                 $time, ga.da, ga.busy, ga.sc, ga.msg, ga.cnt, xa.da, xa.busy, xa.sc, xa.msg, xa.cnt);
      end
    end
    if (qb.size() > 0) begin
      xb = qb.pop_front();
      gb = {if_b.drop_activated, if_b.busy, if_b.state_code, if_b.msg_sel, if_b.drop_count};
      checks++;
      if (gb !== xb) begin
        errors++;
        $display("FAIL dut_b t=%0t got da=%b busy=%b sc=%0d msg=%0d cnt=%0d want da=%b busy=%b sc=%0d msg=%0d cnt=%0d",
                 $time, gb.da, gb.busy, gb.sc, gb.msg, gb.cnt, xb.da, xb.busy, xb.sc, xb.msg, xb.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_a.sample_valid = 1'b0; if_a.t_act = '0; if_a.t_lim = '0; if_a.drop_en = 1'b0; if_a.abort = 1'b0;
    if_b.sample_valid = 1'b0; if_b.t_act = '0; if_b.t_lim = '0; if_b.drop_en = 1'b0; if_b.abort = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Basic confirm-and-fire sequence.
    repeat (3) samp(80, 100, 1'b1);
    idle(30);

    // Hot sample breaks the streak, then a full streak fires.
    samp(80, 100, 1'b1); samp(80, 100, 1'b1); samp(120, 100, 1'b1);
    repeat (3) samp(80, 100, 1'b1);
    idle(30);

    // Abort during DROP, then qualifying samples throughout COOL.
    repeat (3) samp(80, 100, 1'b1);
    idle(2);
    cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
    repeat (20) samp(80, 100, 1'b1);
    idle(10);

    // Disabled unit: cold message, then equal temperatures hold it.
    samp(50, 100, 1'b0); samp(100, 100, 1'b0); samp(100, 100, 1'b1); samp(150, 100, 1'b0);
    idle(3);

    // Reset in the middle of a drop, then a full streak again.
    repeat (3) samp(80, 100, 1'b1);
    idle(2);
    cycle(1'b1, 80, 100, 1'b1, 1'b0, 1'b1);
    repeat (3) samp(80, 100, 1'b1);
    idle(30);

    // Randomised traffic around the threshold.
    for (int i = 0; i < 3000; i++) begin
      int lim, act;
      lim = $urandom_range(100, 60000);
      act = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : lim + int'($urandom_range(0, 6)) - 3;
      cycle($urandom_range(0, 3) != 0, act, lim, $urandom_range(0, 15) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 499) == 0);
    end

    // Back-to-back drops from a clean reset to reach counter saturation.
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    repeat (1200) samp(10, 20, 1'b1);
    idle(5);

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    #1;
    if (qa.size() > 0 || qb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", qa.size() + qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drop_sequencer.md
# drop_sequencer

Sequencing controller for the drop actuator. It qualifies temperature samples (`t_act` against `t_lim`, gated by `drop_en`) over several consecutive samples before firing. It then holds the drop output for a fixed pulse and enforces a cooldown before re-arming. It also exports a registered 2-bit message code that the seven-segment display path decodes.

## Interface
- `CONFIRM`, default 3: consecutive qualifying samples required before a drop; legal range 1..15.
- `DROP_CYCLES`, default 8: drop pulse length in clocks; legal range 1..65535.
- `COOL_CYCLES`, default 16: cooldown length in clocks; legal range 1..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_valid` in 1: `t_act` and `t_lim` are valid this cycle.
- `t_act` in 16: measured temperature, unsigned.
- `t_lim` in 16: temperature limit, unsigned.
- `drop_en` in 1: drop enable; level-sensitive.
- `abort` in 1: terminates an active drop.
- `drop_activated` out 1: actuator drive, registered.
- `busy` out 1: high in ARM, DROP and COOL states.
- `state_code` out 2: encoding IDLE=0, ARM=1, DROP=2, COOL=3.
- `msg_sel` out 2: display message; BLANK=0, HOT=1, DROP=2, COLD=3.
- `drop_count` out 8: number of drops since reset; saturates at 255.

## Operation
- A sample is **qualifying** when `sample_valid`, `drop_en` and `t_act < t_lim` are all high. Compares are 16-bit unsigned.
- **IDLE**
  - A qualifying sample sets conf_cnt=1.
  - If CONFIRM=1, go to DROP; otherwise go to ARM.
- **ARM**
  - A qualifying sample increments conf_cnt. When conf_cnt reaches CONFIRM, go to DROP.
  - A valid non-qualifying sample clears conf_cnt and returns to IDLE.
  - Cycles without `sample_valid` hold state and count.
  - `drop_en` low while in ARM also returns to IDLE.
- **DROP**
  - On entry: timer=DROP_CYCLES, `drop_activated`=1, `drop_count`++ (saturating).
  - Timer decrements every cycle. When timer==1, go to COOL.
  - `abort`=1 or `drop_en`=0 moves to COOL on the next edge; this takes priority over timer expiry.
  - Samples are ignored.
- **COOL**
  - On entry: timer=COOL_CYCLES, `drop_activated`=0.
  - When timer==1, go to IDLE with conf_cnt=0.
  - `abort` has no effect. Samples are ignored.
- **msg_sel**
  - Forced to DROP whenever the next state is DROP.
  - Otherwise updated on each valid sample:
    - HOT if `drop_en` and `t_act > t_lim`.
    - COLD if !`drop_en` and `t_act < t_lim`.
    - BLANK if `drop_en` and `t_act < t_lim`.
  - `t_act == t_lim`, or !`drop_en` with `t_act >= t_lim`, holds the previous value.
  - On leaving DROP, `msg_sel` holds DROP until the next valid sample.

## Timing
- Reset values: state=IDLE, `drop_activated`=0, `busy`=0, `state_code`=0, `msg_sel`=BLANK, `drop_count`=0, conf_cnt=0, timer=0.
- All outputs are registered.
- `drop_activated` rises on the same edge that captures the CONFIRM-th qualifying sample, which is 1 clock of latency from that sample.
- Unless aborted, `drop_activated` stays high exactly DROP_CYCLES clocks. It is followed by exactly COOL_CYCLES clocks in COOL before IDLE.
- Abort latency is 1 clock: `drop_activated` is low on the edge after `abort` is sampled high.
- The earliest re-drop follows COOL, then a fresh CONFIRM samples.
- Reset asserted mid-DROP clears `drop_activated` on that edge. No cooldown is applied, and `drop_count` is cleared.
- `drop_count` at 255 stays at 255 on further drops.

## Structure
- Package `drop_pkg` holds:
  - the state encoding;
  - the msg_sel codes;
  - the seven-segment pattern constants for BLANK, HOT ("Hot"), DROP ("drOP") and COLD ("CoLd"), active-high, segment order g..a;
  - the default parameter values.
- Sub-module `drop_timer`: a 16-bit loadable down-counter with `load`, `value`, and an `expire` flag (count==1). One instance, shared by DROP and COOL.
- Top level: FSM, confirm counter, message register and drop counter.

## Test plan
- CONFIRM=3, `drop_en`=1, `t_lim`=100; three valid samples at `t_act`=80 -> `drop_activated` high from edge 3 for exactly 8 clocks; `drop_count`=1; `msg_sel`=2; `state_code` sequence 1,1,2,3,0.
- Qualifying, qualifying, then `t_act`=120 -> return to IDLE, no drop, `msg_sel`=HOT; then three qualifying samples -> drop fires.
- `abort` at DROP cycle 3 -> `drop_activated` low next edge; COOL lasts 16 clocks; qualifying samples during COOL do not arm.
- `drop_en`=0 with `t_act`=50, `t_lim`=100 -> `msg_sel`=COLD, state stays IDLE; `t_act`=`t_lim` -> `msg_sel` holds.
- `rst` pulsed during DROP -> all outputs return to reset values on that edge; the next drop requires a full CONFIRM sequence.
- 256 back-to-back drop cycles with CONFIRM=1 -> `drop_count` saturates at 255.
